// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO width, packer state type and ratio helper
package fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  typedef enum logic {ST_EMPTY, ST_PARTIAL} pack_state_t;
  function automatic int ratio(input int in_w, input int data_w);
    return data_w / in_w;
  endfunction
endpackage

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs narrow valid/ready beats into FIFO words, closes partial words on in_last/flush with zero padding, and counts writes and padded words
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH = 2,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic [CNT_WIDTH-1:0]  words_written,
  output logic [CNT_WIDTH-1:0]  pad_words
);
  localparam int RATIO = ratio(IN_WIDTH, DATA_WIDTH);
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST = IW'(RATIO - 1);
  pack_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, data_q, data_d, word;
  logic out_vld_q, out_vld_d, pend_q, pend_d;
  logic [CNT_WIDTH-1:0] words_q, words_d, pad_q, pad_d;
  logic take, flush_req, load, padded;
  always_comb begin
    fifo_wr_en = out_vld_q && !fifo_full;
    in_ready = !rst && (!out_vld_q || !fifo_full);
    take = in_valid && in_ready;
    flush_req = flush || pend_q;
    word = acc_q | (take ? DATA_WIDTH'(in_data) << (32'(idx_q) * IN_WIDTH) : '0);
    load = take ? (idx_q == LAST || in_last || flush_req) : (flush_req && state_q == ST_PARTIAL && in_ready);
    padded = load && !(take && idx_q == LAST);
    idx_d = load ? '0 : idx_q + IW'(take);
    state_d = idx_d == '0 ? ST_EMPTY : ST_PARTIAL;
    acc_d = load ? '0 : word;
    pend_d = flush_req && state_q == ST_PARTIAL && !load;
    out_vld_d = load || (out_vld_q && !fifo_wr_en);
    data_d = load ? word : data_q;
    words_d = words_q + CNT_WIDTH'(fifo_wr_en);
    pad_d = pad_q + CNT_WIDTH'(padded);
  end
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      idx_q <= '0;
      acc_q <= '0;
      data_q <= '0;
      out_vld_q <= 1'b0;
      pend_q <= 1'b0;
      words_q <= '0;
      pad_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      data_q <= data_d;
      out_vld_q <= out_vld_d;
      pend_q <= pend_d;
      words_q <= words_d;
      pad_q <= pad_d;
    end
  end
  assign fifo_data = data_q;
  assign words_written = words_q;
  assign pad_words = pad_q;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: scoreboard bench with a beat-list reference model for fifo_wr_packer
module tb_fifo_wr_packer;
  localparam int IW = 2, DW = 8, CW = 4, R = DW / IW;
  logic wr_clk = 0, rst = 1, in_valid = 0, in_last = 0, flush = 0, fifo_full = 0;
  logic [IW-1:0] in_data = '0;
  logic in_ready, fifo_wr_en;
  logic [DW-1:0] fifo_data;
  logic [CW-1:0] words_written, pad_words;
  fifo_wr_packer #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .wr_clk(wr_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .flush(flush), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .words_written(words_written), .pad_words(pad_words)
  );
  always #5 wr_clk = ~wr_clk;
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] q[$];
  logic [IW-1:0] beats[$];
  logic pend = 0, exp_rdy = 0, took = 0;
  logic [CW-1:0] exp_w = '0, exp_pad = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge wr_clk) begin
    #1;
    if (rst) begin
      q.delete();
      exp_w = '0;
      exp_pad = '0;
      chk("rst_data", 32'(fifo_data), 0);
    end
    exp_rdy = !rst && !(q.size() > 0 && fifo_full);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("wr_en", 32'(fifo_wr_en), 32'(!rst && q.size() > 0 && !fifo_full));
    chk("words_written", 32'(words_written), 32'(exp_w));
    chk("pad_words", 32'(pad_words), 32'(exp_pad));
    if (q.size() > 0) chk("fifo_data", 32'(fifo_data), 32'(q[0]));
    if (!rst && q.size() > 0 && !fifo_full) begin
      void'(q.pop_front());
      exp_w++;
    end
  end
  task automatic close_word();
    logic [DW-1:0] w;
    w = '0;
    foreach (beats[i]) w |= DW'(beats[i]) << (i * IW);
    q.push_back(w);
    if (beats.size() < R) exp_pad++;
    beats.delete();
  endtask
  task automatic cyc(input logic r, input logic v, input logic [IW-1:0] d, input logic l, input logic f, input logic full);
    logic fr;
    @(negedge wr_clk);
    rst = r; in_valid = v; in_data = d; in_last = l; flush = f; fifo_full = full;
    #2;
    took = 0;
    if (rst) begin
      beats.delete();
      pend = 0;
    end else begin
      fr = flush || pend;
      took = in_valid && exp_rdy;
      if (took) begin
        beats.push_back(in_data);
        if (beats.size() == R || in_last || fr) close_word();
        pend = 0;
      end else if (fr && beats.size() > 0) begin
        if (exp_rdy) begin
          close_word();
          pend = 0;
        end else pend = 1;
      end else pend = 0;
    end
  endtask
  task automatic send(input logic [IW-1:0] d, input logic l);
    for (int i = 0; i < 50; i++) begin
      cyc(0, 1, d, l, 0, 0);
      if (took) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: beat %0h not accepted within 50 cycles", d);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0);
    send(1, 0); send(2, 0); send(3, 0); send(0, 0);
    idle(2);
    send(3, 0); send(1, 1);
    idle(2);
    send(1, 0); send(2, 0); send(3, 0); send(0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    send(1, 0); send(2, 0); send(3, 0);
    idle(2);
    send(2, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    send(1, 0); send(2, 0);
    cyc(1, 0, 0, 0, 0, 0);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    idle(2);
    for (int w = 0; w < 17; w++)
      for (int b = 0; b < R; b++) send(IW'($urandom), 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 299) == 0, v, IW'($urandom), $urandom_range(0, 7) == 0,
          !v && $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end
    idle(4);
    chk("drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side front end for the team's asynchronous FIFO, running entirely in the `wr_clk` domain. It accepts a narrow valid/ready stream, packs `RATIO = DATA_WIDTH/IN_WIDTH` beats into one FIFO word, and drives the FIFO's `wr_en`/`data_in`, honouring `full` so that the FIFO never sees a write while full. Partial words are closed by `in_last` or `flush` and zero-padded.

## Interface
- `IN_WIDTH`, default 2: input beat width; must divide `DATA_WIDTH`, with `RATIO >= 2`.
- `DATA_WIDTH`, default 8: FIFO word width; matches the FIFO `data_width`.
- `CNT_WIDTH`, default 16: width of the statistics counters.
- `wr_clk  in  1`: write clock, shared with the FIFO write port.
- `rst  in  1`: reset, asynchronous, active-high; clock `wr_clk`.
- `in_valid  in  1`: input beat valid.
- `in_data  in  IN_WIDTH`: input beat.
- `in_last  in  1`: closes the current word after this beat; qualified by `in_valid`.
- `in_ready  out  1`: beat accepted on an edge where `in_valid && in_ready`.
- `flush  in  1`: single-cycle request to emit a pending partial word.
- `fifo_full  in  1`: FIFO `full` flag.
- `fifo_wr_en  out  1`: connects to FIFO `wr_en`.
- `fifo_data  out  DATA_WIDTH`: connects to FIFO `data_in`.
- `words_written  out  CNT_WIDTH`: count of FIFO writes; wraps.
- `pad_words  out  CNT_WIDTH`: count of words emitted with zero padding; wraps.

## Operation
- State `ST_EMPTY`: lane index `idx = 0`, no partial data. State `ST_PARTIAL`: `1 <= idx <= RATIO-1` lanes are filled.
- Lane packing: an accepted beat is written to bits `[idx*IN_WIDTH +: IN_WIDTH]`. Lane 0 is the LSBs.
- A word completes on an accepted beat when `idx == RATIO-1` or `in_last` is set.
  - The completed word (unfilled lanes = 0) loads the output register and sets `out_vld`.
  - `idx` returns to 0 and the state returns to `ST_EMPTY`.
  - The word counts in `pad_words` if it was closed before lane `RATIO-1`.
- `flush` in `ST_PARTIAL` with no accepted beat that cycle completes the word as padded. If the output register is occupied, the flush request is held until it is free.
- `flush` in `ST_EMPTY` has no effect.
- `flush` in the same cycle as an accepted beat: the beat is included, then the word closes (same as `in_last`).
- Output path:
  - `fifo_wr_en = out_vld && !fifo_full` (combinational).
  - `out_vld` clears after an edge with `fifo_wr_en = 1`, unless a new word loads on the same edge.
- Input handshake: `in_ready = !rst && (!out_vld || !fifo_full)`. A completing beat may load while the old word drains on the same edge.
- `words_written` increments on every edge with `fifo_wr_en = 1`.
- Reset values: `out_vld = 0`, `fifo_data = 0`, `idx = 0`, `ST_EMPTY`, pending flush = 0, both counters = 0. Therefore `fifo_wr_en = 0` and `in_ready = 0` while `rst` is high.
- Reset mid-word discards the partial data; no write occurs.

## Timing
- Completing beat accepted at edge N → `out_vld` high after edge N → `fifo_wr_en` high in cycle N+1 if `fifo_full = 0` → FIFO captures at edge N+1.
- `fifo_data` is stable whenever `out_vld` is high and no write has occurred. While `fifo_full` is held, `fifo_data` does not change.
- Sustained throughput is one FIFO word per `RATIO` input beats with no bubbles, as long as `fifo_full = 0`.
- When `fifo_full` deasserts, the pending write goes out in that same cycle and `in_ready` rises combinationally.
- No combinational path from `in_valid`/`in_data` to `fifo_wr_en`/`fifo_data`.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_DATA_WIDTH` (8), shared with the FIFO.
  - The `pack_state_t` enum (`ST_EMPTY`, `ST_PARTIAL`).
  - The derived-constant function `ratio(in_w, data_w)`.
- Single module; no sub-module is warranted. Counters and lane decode stay inline.

## Test plan
- Reset, then beats 1,2,3,0 back-to-back, `fifo_full = 0` → one write, `fifo_data = 8'h39`, one cycle after the 4th beat; `words_written = 1`, `pad_words = 0`.
- Beats 3, then 1 with `in_last` → `fifo_data = 8'h07`; `pad_words = 1`; `idx` back to 0.
- `fifo_full = 1` with a word pending and 4 more beats offered:
  - `in_ready = 0`, `fifo_wr_en = 0`, `fifo_data` held.
  - Drop `fifo_full` → write in that cycle; the next word (e.g. `8'hE4` from beats 0,1,2,3) follows with no loss.
- Beat 2, then a `flush` pulse → `fifo_data = 8'h02`, `pad_words` increments. A `flush` in `ST_EMPTY` → no write.
- Two beats accepted, then `rst` pulsed → no write. Next beats 1,1,1,1 → `fifo_data = 8'h55`, `words_written = 1`.
- `CNT_WIDTH = 4`, 16 full words written → `words_written` wraps to 0; the 17th write gives 1.
